// File: rtl/square_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : square_rr_scheduler
//  Purpose  : Round-robin scheduler sharing one squaring datapath between
//             NREQ requesters. Arbitrates requests, latches the winner's
//             operand, squares it and returns the 2W-bit result tagged with
//             the requester index.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1        rising-edge clock
//    rst_n    in   1        synchronous active-low reset
//    req      in   NREQ     per-requester request level
//    operand  in   NREQ*W   flattened operands, requester i at [i*W +: W]
//    gnt      out  NREQ     one-hot acceptance pulse (one cycle)
//    busy     out  1        high while the FSM is not IDLE
//    done     out  1        result-valid pulse (one cycle)
//    done_id  out  IDW      requester index belonging to result
//    result   out  2*W      square of the accepted operand (held until next done)
// ----------------------------------------------------------------------------
//  Build option
//    SQ_FAST_EN  defined   : single-cycle CALC using a combinational multiply
//                undefined : W-cycle shift-add iteration, no multiplier
// ============================================================================
module square_rr_scheduler #(
   parameter int NREQ = 4,
   parameter int W    = 8,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*W-1:0]    operand,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 done,
   output logic [IDW-1:0]       done_id,
   output logic [2*W-1:0]       result
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   logic [W-1:0]      op_q;
   logic [IDW-1:0]    id_q;
   logic [IDW-1:0]    ptr;       // index of the most recently served requester

   // ------------------------------------------------------------------------
   // Round-robin pick: scan ptr+1, ptr+2, ... with natural IDW-bit wrap
   // (NREQ is a power of two). The final step k=NREQ lands back on ptr, so
   // the last served requester has the lowest priority.
   // ------------------------------------------------------------------------
   logic [IDW-1:0]    winner;
   logic [IDW-1:0]    cand;
   logic              any_req;
   logic [W-1:0]      win_op;

   always_comb begin
      winner  = '0;
      cand    = '0;
      any_req = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = ptr + IDW'(k);
         if (!any_req && req[cand]) begin
            winner  = cand;
            any_req = 1'b1;
         end
      end
      win_op = operand[int'(winner)*W +: W];
   end

   // Zero-extended operand so every product term is computed at 2W bits,
   // which is wide enough that the running sum never overflows.
   logic [2*W-1:0]    op_ext;
   assign op_ext = {{W{1'b0}}, op_q};

`ifdef SQ_FAST_EN
   // Whole square in one CALC cycle; it goes straight into result, so no
   // separate accumulator is kept.
   logic [2*W-1:0]    sq;
   assign sq = op_ext * op_ext;
`else
   localparam int          CW       = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   logic [CW-1:0]     cnt;
   logic [2*W-1:0]    acc;
   logic [2*W-1:0]    partial;
   logic [2*W-1:0]    acc_nxt;

   // One shift-add step: add op << cnt when bit cnt of the operand is set.
   assign partial = op_q[cnt] ? (op_ext << cnt) : '0;
   assign acc_nxt = acc + partial;
`endif

   // ------------------------------------------------------------------------
   // Control FSM with registered outputs. gnt and done default low every
   // cycle so each is a single-cycle pulse.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         result  <= '0;
         op_q    <= '0;
         id_q    <= '0;
         ptr     <= IDW'(NREQ - 1);   // requester 0 has first priority
`ifndef SQ_FAST_EN
         acc     <= '0;
         cnt     <= '0;
`endif
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  op_q  <= win_op;
                  id_q  <= winner;
                  gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << winner;
                  busy  <= 1'b1;
                  state <= CALC;
`ifndef SQ_FAST_EN
                  acc   <= '0;
                  cnt   <= '0;
`endif
               end
            end

            CALC: begin
`ifdef SQ_FAST_EN
               result  <= sq;
               done_id <= id_q;
               done    <= 1'b1;
               state   <= DONE;
`else
               acc <= acc_nxt;
               cnt <= cnt + 1'b1;
               // result is loaded with the final sum on the edge that
               // enters DONE so that done and result appear together.
               if (cnt == CNT_LAST) begin
                  result  <= acc_nxt;
                  done_id <= id_q;
                  done    <= 1'b1;
                  state   <= DONE;
               end
`endif
            end

            DONE: begin
               // req is deliberately not sampled here: the next acceptance
               // happens from IDLE, giving W+2 cycles per square.
               ptr   <= id_q;
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_square_rr_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_square_rr_scheduler
//  Purpose  : Self-checking bench for square_rr_scheduler. Scenario tasks
//             drive requests, check grants inline and push the expected
//             (id, square) pairs to a queue; a monitor pops and compares on
//             every done pulse, including done latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_square_rr_scheduler;

   localparam int NREQ = 4;
   localparam int W    = 8;
   localparam int IDW  = 2;
`ifdef SQ_FAST_EN
   localparam int LAT  = 1;
`else
   localparam int LAT  = W;
`endif
   localparam int ABORT = (LAT > 4) ? 4 : LAT - 1;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req;
   logic [NREQ*W-1:0]   operand;
   logic [NREQ-1:0]     gnt;
   logic                busy;
   logic                done;
   logic [IDW-1:0]      done_id;
   logic [2*W-1:0]      result;

   always #5 clk = ~clk;

   square_rr_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .operand (operand),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .done_id (done_id),
      .result  (result)
   );

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [2*W-1:0] res;
   } exp_t;

   exp_t            sb[$];
   int              total = 0;
   int              bad   = 0;
   int              cyc   = 0;
   int              gcyc  = 0;
   logic            mon_en = 1'b0;
   logic [NREQ-1:0] prev_gnt = '0;
   logic            prev_done = 1'b0;

   always @(posedge clk) cyc++;

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         if (gnt != '0) begin
            total++;
            if (prev_gnt != '0) begin
               bad++;
               $display("FAIL gnt_pulse: gnt high two cycles (%b then %b), required one", prev_gnt, gnt);
            end
            gcyc = cyc;
         end
         if (done) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_done: done_id=%0d result=%0d, no result expected", done_id, result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (done_id !== e.id || result !== e.res) begin
                  bad++;
                  $display("FAIL result: got id=%0d res=%0d, required id=%0d res=%0d", done_id, result, e.id, e.res);
               end
            end
            total++;
            if (cyc - gcyc != LAT || prev_done) begin
               bad++;
               $display("FAIL done_latency: got %0d cycles after gnt (prev_done=%b), required %0d", cyc - gcyc, prev_done, LAT);
            end
         end
         prev_gnt  = gnt;
         prev_done = done;
      end
   end

   // ---------------- stimulus helpers (no checks) ----------------
   task automatic set_op(input int i, input int v);
      operand[i*W +: W] = v[W-1:0];
   endtask

   task automatic push_exp(input int id, input int op);
      exp_t e;
      int   p;
      p     = op * op;
      e.id  = id[IDW-1:0];
      e.res = p[2*W-1:0];
      sb.push_back(e);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = '0;
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic wait_gnt(output logic [NREQ-1:0] g);
      g = '0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (gnt != '0) begin
            g = gnt;
            break;
         end
      end
      if (g == '0) begin
         total++;
         bad++;
         $display("FAIL gnt_timeout: gnt=%b, required a grant within 100 cycles", gnt);
      end
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 300; n++) begin
         if (sb.size() == 0 && busy == 1'b0) break;
         @(negedge clk);
      end
      if (sb.size() != 0 || busy != 1'b0) begin
         total++;
         bad++;
         $display("FAIL done_timeout: pending=%0d busy=%b, required 0 and 0", sb.size(), busy);
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      operand = '0;
      do_reset();
      @(negedge clk);
      total++;
      if (gnt !== '0) begin bad++; $display("FAIL reset_gnt: got %b required 0000", gnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", done); end
      total++;
      if (done_id !== '0 || result !== '0) begin
         bad++; $display("FAIL reset_result: got id=%0d res=%0d required 0 0", done_id, result);
      end
   endtask

   task automatic test_single();
      logic [NREQ-1:0] g;
      set_op(0, 5);
      req = 4'b0001;
      push_exp(0, 5);
      wait_gnt(g);
      total++;
      if (g !== 4'b0001) begin bad++; $display("FAIL single_gnt: got %b required 0001", g); end
      req = '0;
      @(negedge clk);
      total++;
      if (gnt !== '0 || busy !== 1'b1) begin
         bad++; $display("FAIL single_pulse: got gnt=%b busy=%b required 0000 1", gnt, busy);
      end
      wait_idle();
      total++;
      if (result !== 16'd25 || done_id !== 2'd0) begin
         bad++; $display("FAIL single_hold: got res=%0d id=%0d required 25 0", result, done_id);
      end
   endtask

   task automatic test_back_to_back();
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] eg;
      int ops[4] = '{3, 7, 15, 255};
      int prev = 0;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         set_op(i, ops[i]);
         push_exp(i, ops[i]);
      end
      req = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g);
         eg = 4'b0001 << i;
         total++;
         if (g !== eg) begin bad++; $display("FAIL b2b_gnt%0d: got %b required %b", i, g, eg); end
         if (i > 0) begin
            total++;
            if (cyc - prev != LAT + 2) begin
               bad++; $display("FAIL b2b_spacing%0d: got %0d cycles required %0d", i, cyc - prev, LAT + 2);
            end
         end
         prev = cyc;
         req[i] = 1'b0;
      end
      wait_idle();
   endtask

   task automatic test_alternate();
      logic [NREQ-1:0] g;
      logic [NREQ-1:0] eg;
      int ids[4] = '{0, 2, 0, 2};
      do_reset();
      set_op(0, 2);
      set_op(2, 4);
      for (int i = 0; i < 4; i++) push_exp(ids[i], (ids[i] == 0) ? 2 : 4);
      req = 4'b0101;
      for (int i = 0; i < 4; i++) begin
         wait_gnt(g);
         eg = 4'b0001 << ids[i];
         total++;
         if (g !== eg) begin bad++; $display("FAIL alt_gnt%0d: got %b required %b", i, g, eg); end
      end
      req = '0;
      wait_idle();
   endtask

   task automatic test_boundary();
      logic [NREQ-1:0] g;
      set_op(3, 0);
      push_exp(3, 0);
      req = 4'b1000;
      wait_gnt(g);
      total++;
      if (g !== 4'b1000) begin bad++; $display("FAIL bnd_gnt0: got %b required 1000", g); end
      req = '0;
      wait_idle();
      set_op(3, 255);
      push_exp(3, 255);
      req = 4'b1000;
      wait_gnt(g);
      total++;
      if (g !== 4'b1000) begin bad++; $display("FAIL bnd_gnt255: got %b required 1000", g); end
      req = '0;
      set_op(3, 1);          // after acceptance: must not affect the result
      wait_idle();
      total++;
      if (result !== 16'd65025) begin bad++; $display("FAIL bnd_late_op: got %0d required 65025", result); end
   endtask

   task automatic test_reset_mid();
      logic [NREQ-1:0] g;
      set_op(0, 200);
      req = 4'b0001;
      wait_gnt(g);
      req = '0;
      repeat (ABORT) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || gnt !== '0) begin
         bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b gnt=%b required 0 0 0000", busy, done, gnt);
      end
      total++;
      if (result !== '0 || done_id !== '0) begin
         bad++; $display("FAIL midrst_out: got res=%0d id=%0d required 0 0", result, done_id);
      end
      repeat (LAT + 4) @(negedge clk);   // monitor flags any stray done
      set_op(0, 9);
      set_op(1, 6);
      push_exp(0, 9);
      push_exp(1, 6);
      req = 4'b0011;
      wait_gnt(g);
      total++;
      if (g !== 4'b0001) begin bad++; $display("FAIL midrst_first: got %b required 0001", g); end
      req[0] = 1'b0;
      wait_gnt(g);
      total++;
      if (g !== 4'b0010) begin bad++; $display("FAIL midrst_second: got %b required 0010", g); end
      req = '0;
      wait_idle();
   endtask

   task automatic test_wrap();
      logic [NREQ-1:0] g;
      set_op(3, 11);
      push_exp(3, 11);
      req = 4'b1000;
      wait_gnt(g);
      total++;
      if (g !== 4'b1000) begin bad++; $display("FAIL wrap_gnt3: got %b required 1000", g); end
      req = '0;
      wait_idle();
      set_op(0, 13);
      set_op(1, 17);
      push_exp(0, 13);
      push_exp(1, 17);
      req = 4'b0011;
      wait_gnt(g);
      total++;
      if (g !== 4'b0001) begin bad++; $display("FAIL wrap_gnt0: got %b required 0001", g); end
      req[0] = 1'b0;
      wait_gnt(g);
      total++;
      if (g !== 4'b0010) begin bad++; $display("FAIL wrap_gnt1: got %b required 0010", g); end
      req = '0;
      wait_idle();
   endtask

   initial begin
      rst_n   = 1'b0;
      req     = '0;
      operand = '0;
      test_reset();
      test_single();
      test_back_to_back();
      test_alternate();
      test_boundary();
      test_reset_mid();
      test_wrap();
      repeat (4) @(negedge clk);
      total++;
      if (sb.size() != 0) begin bad++; $display("FAIL leftover: %0d results never returned, required 0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
